bank_cmd_fsm: RTL and testbench
===============================

BANK_CMD_FSM -- requirements
Module: bank_cmd_fsm

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 17, row address width.
REQ-002 SHALL have parameter TRCD, default 4, ACT-to-active delay in clk cycles (>=1).
REQ-003 SHALL have parameter TRP, default 4, precharge duration in clk cycles (>=1).
REQ-004 SHALL have parameter TBL, default 4, read/write burst duration in clk cycles (>=1).
REQ-005 SHALL have: clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have: act  input  1  activate command strobe.
REQ-008 SHALL have: rd  input  1  read command strobe.
REQ-009 SHALL have: wr  input  1  write command strobe.
REQ-010 SHALL have: pre  input  1  precharge command strobe.
REQ-011 SHALL have: row  input  ADDRWIDTH  row address, sampled with act.
REQ-012 SHALL have: stall  input  1  hold request from the downstream MEMSync stage.
REQ-013 SHALL have: BankFSM  output  5  registered state code to MEMSync.
REQ-014 SHALL have: RowId  output  ADDRWIDTH  registered open-row address to MEMSync.
REQ-015 SHALL have: busy  output  1  high in any timed state.
REQ-016 SHALL have: cmd_err  output  1  one-cycle pulse on an illegal or ignored command.

Function
REQ-017 SHALL encode states on BankFSM: IDLE 5'b00000, ACTIVATING 5'b00011, ACTIVE 5'b00100, READING 5'b01011, WRITING 5'b10010, PRECHARGING 5'b01010.
REQ-018 SHALL treat a cycle with more than one of act/rd/wr/pre high as illegal: cmd_err=1, no state change.
REQ-019 SHALL, in IDLE with act, latch row into RowId and enter ACTIVATING on the next edge; rd/wr/pre in IDLE -> cmd_err.
REQ-020 SHALL hold ACTIVATING for exactly TRCD cycles, then enter ACTIVE; any command during ACTIVATING -> cmd_err, ignored.
REQ-021 SHALL, in ACTIVE: rd -> READING, wr -> WRITING, pre -> PRECHARGING, all on the next edge; act -> cmd_err, RowId unchanged.
REQ-022 SHALL hold READING or WRITING for exactly TBL non-stalled cycles, then return to ACTIVE; commands during a burst -> cmd_err.
REQ-023 SHALL hold PRECHARGING for exactly TRP non-stalled cycles, then enter IDLE; RowId retains its last value until the next act.
REQ-024 SHALL, while stall=1 in READING/WRITING/PRECHARGING, freeze both state and down-counter; commands then -> cmd_err.
REQ-025 SHALL ignore stall in IDLE, ACTIVATING and ACTIVE (tRCD is not stretchable).
REQ-026 SHALL drive busy=1 in ACTIVATING, READING, WRITING, PRECHARGING; 0 otherwise.
REQ-027 SHALL size the internal down-counter to hold max(TRCD,TRP,TBL) with no wrap; reload on every timed-state entry.
REQ-028 SHALL register all outputs; no combinational input-to-output path.

Reset
REQ-029 SHALL, on reset=1 at a rising edge, force state IDLE, BankFSM=0, RowId=0, busy=0, cmd_err=0, counter=0, regardless of current state or inputs.
REQ-030 SHALL, on reset asserted mid-burst or mid-precharge, abandon the operation without emitting cmd_err.
REQ-031 SHALL accept a command in the first cycle after reset deasserts.

Verification
REQ-032 Reset, act with row=17'h1ABCD -> BankFSM=5'b00011 for 4 cycles, then 5'b00100, RowId=17'h1ABCD, busy 1 for 4 cycles.
REQ-033 From ACTIVE, wr -> BankFSM=5'b10010 for 4 cycles then 5'b00100; rd -> 5'b01011 for 4 cycles then 5'b00100.
REQ-034 In WRITING, stall=1 for 3 cycles at burst cycle 2 -> WRITING lasts 7 cycles total, no cmd_err.
REQ-035 pre from ACTIVE -> 5'b01010 for 4 cycles, then 5'b00000, RowId still 17'h1ABCD; then rd in IDLE -> cmd_err one cycle, BankFSM stays 0.
REQ-036 act+wr in same cycle in ACTIVE -> cmd_err=1, state stays ACTIVE; act during READING -> cmd_err, RowId unchanged.
REQ-037 reset=1 at burst cycle 2 of READING -> next cycle BankFSM=0, RowId=0, busy=0, cmd_err=0.

Source files
------------

// File: rtl/bank_cmd_fsm.sv
// Single-bank command FSM. It tracks one DRAM bank through activate, read/write
// bursts and precharge. The state, the open row, busy and cmd_err all come
// from registers, so no input reaches an output within the same cycle.
module bank_cmd_fsm #(
    parameter int unsigned ADDRWIDTH = 17,
    parameter int unsigned TRCD      = 4,
    parameter int unsigned TRP       = 4,
    parameter int unsigned TBL       = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 act,
    input  logic                 rd,
    input  logic                 wr,
    input  logic                 pre,
    input  logic [ADDRWIDTH-1:0] row,
    input  logic                 stall,
    output logic [4:0]           BankFSM,
    output logic [ADDRWIDTH-1:0] RowId,
    output logic                 busy,
    output logic                 cmd_err
);

    localparam int unsigned MaxTrcdTrp = (TRCD > TRP) ? TRCD : TRP;
    localparam int unsigned MaxCnt     = (MaxTrcdTrp > TBL) ? MaxTrcdTrp : TBL;
    localparam int unsigned CntW       = $clog2(MaxCnt + 1);

    // The encoding is visible downstream, so the state register drives BankFSM directly
    typedef enum logic [4:0] {
        StIdle        = 5'b00000,
        StActivating  = 5'b00011,
        StActive      = 5'b00100,
        StReading     = 5'b01011,
        StWriting     = 5'b10010,
        StPrecharging = 5'b01010
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [ADDRWIDTH-1:0]  row_id_q, row_id_d;
    logic                  busy_q, busy_d;
    logic                  cmd_err_q, cmd_err_d;

    logic [2:0] n_cmds;
    logic       multi_cmd;
    logic       any_cmd;

    assign n_cmds    = {2'b00, act} + {2'b00, rd} + {2'b00, wr} + {2'b00, pre};
    assign multi_cmd = (n_cmds > 3'd1);
    assign any_cmd   = (n_cmds != 3'd0);

    // State, counter and output registers; reset abandons any operation silently
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            row_id_q  <= '0;
            busy_q    <= 1'b0;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_id_q  <= row_id_d;
            busy_q    <= busy_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    // Next state and down-counter; the counter reloads on each timed-state entry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (!multi_cmd && act) begin
                    state_d = StActivating;
                    cnt_d   = CntW'(TRCD);
                end
            end
            StActivating: begin
                // tRCD cannot be stretched, so stall is ignored here
                if (cnt_q <= CntW'(1)) begin
                    state_d = StActive;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StActive: begin
                if (!multi_cmd) begin
                    if (rd) begin
                        state_d = StReading;
                        cnt_d   = CntW'(TBL);
                    end else if (wr) begin
                        state_d = StWriting;
                        cnt_d   = CntW'(TBL);
                    end else if (pre) begin
                        state_d = StPrecharging;
                        cnt_d   = CntW'(TRP);
                    end
                end
            end
            StReading, StWriting: begin
                if (!stall) begin
                    if (cnt_q <= CntW'(1)) begin
                        state_d = StActive;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            StPrecharging: begin
                if (!stall) begin
                    if (cnt_q <= CntW'(1)) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Next values for the open row, busy and the command-error pulse
    always_comb begin
        row_id_d  = row_id_q;
        cmd_err_d = 1'b0;
        busy_d    = (state_d == StActivating) || (state_d == StReading) ||
                    (state_d == StWriting)    || (state_d == StPrecharging);
        if (multi_cmd) begin
            cmd_err_d = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    cmd_err_d = rd | wr | pre;
                    if (act) begin
                        row_id_d = row;
                    end
                end
                StActive:                                          cmd_err_d = act;
                StActivating, StReading, StWriting, StPrecharging: cmd_err_d = any_cmd;
                default:                                           cmd_err_d = 1'b0;
            endcase
        end
    end

    assign BankFSM = state_q;
    assign RowId   = row_id_q;
    assign busy    = busy_q;
    assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_bank_cmd_fsm.sv
// Scoreboard bench for bank_cmd_fsm: the driver steps a phase/remaining-time
// model of the bank and queues the expected outputs. A monitor pops one entry
// after every rising edge and compares it with the DUT outputs.
module tb_bank_cmd_fsm;

    localparam int AW   = 17;
    localparam int TRCD = 4;
    localparam int TRP  = 4;
    localparam int TBL  = 4;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          act   = 1'b0;
    logic          rd    = 1'b0;
    logic          wr    = 1'b0;
    logic          pre   = 1'b0;
    logic          stall = 1'b0;
    logic [AW-1:0] row   = '0;
    logic [4:0]    BankFSM;
    logic [AW-1:0] RowId;
    logic          busy;
    logic          cmd_err;

    always #5 clk = ~clk;

    bank_cmd_fsm #(
        .ADDRWIDTH (AW),
        .TRCD      (TRCD),
        .TRP       (TRP),
        .TBL       (TBL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .act     (act),
        .rd      (rd),
        .wr      (wr),
        .pre     (pre),
        .row     (row),
        .stall   (stall),
        .BankFSM (BankFSM),
        .RowId   (RowId),
        .busy    (busy),
        .cmd_err (cmd_err)
    );

    typedef struct packed {
        logic [4:0]    fsm;
        logic [AW-1:0] rowid;
        logic          busy;
        logic          err;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: phase 0 idle, 1 activating, 2 active, 3 reading, 4 writing,
    // 5 precharging. m_rem holds the cycles of the timed phase still to run.
    int            m_phase = 0;
    int            m_rem   = 0;
    logic [AW-1:0] m_row   = '0;

    function automatic logic [4:0] phase_code(input int ph);
        case (ph)
            1:       return 5'b00011;
            2:       return 5'b00100;
            3:       return 5'b01011;
            4:       return 5'b10010;
            5:       return 5'b01010;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic step(input logic r, input logic a, input logic rv, input logic wv,
                        input logic p, input logic s, input logic [AW-1:0] rowv);
        int   nc;
        logic err;
        exp_t e;
        @(negedge clk);
        reset = r; act = a; rd = rv; wr = wv; pre = p; stall = s; row = rowv;
        nc  = int'(a) + int'(rv) + int'(wv) + int'(p);
        err = 1'b0;
        if (r) begin
            m_phase = 0; m_rem = 0; m_row = '0;
        end else begin
            case (m_phase)
                0: begin
                    if (nc > 1) err = 1'b1;
                    else if (a) begin
                        m_row = rowv; m_phase = 1; m_rem = TRCD;
                    end else if (nc == 1) err = 1'b1;
                end
                1: begin
                    if (nc > 0) err = 1'b1;
                    m_rem--;
                    if (m_rem == 0) m_phase = 2;
                end
                2: begin
                    if (nc > 1 || a) err = 1'b1;
                    else if (rv) begin m_phase = 3; m_rem = TBL; end
                    else if (wv) begin m_phase = 4; m_rem = TBL; end
                    else if (p)  begin m_phase = 5; m_rem = TRP; end
                end
                default: begin
                    if (nc > 0) err = 1'b1;
                    if (!s) begin
                        m_rem--;
                        if (m_rem == 0) m_phase = (m_phase == 5) ? 0 : 2;
                    end
                end
            endcase
        end
        e.fsm   = phase_code(m_phase);
        e.rowid = m_row;
        e.busy  = (m_phase == 1) || (m_phase >= 3);
        e.err   = err;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Monitor: compare DUT outputs shortly after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_cmp++;
                if (BankFSM !== e.fsm || RowId !== e.rowid || busy !== e.busy ||
                    cmd_err !== e.err) begin
                    n_err++;
                    $display("FAIL outputs t=%0t: got fsm=%b row=%h busy=%b err=%b, want fsm=%b row=%h busy=%b err=%b",
                             $time, BankFSM, RowId, busy, cmd_err, e.fsm, e.rowid, e.busy, e.err);
                end
            end
        end
    end

    initial begin
        int            r;
        logic [3:0]    c;
        logic [AW-1:0] rv;
        // Reset, then act in the very first cycle after reset releases
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 17'h1FFFF);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 17'h1ABCD);
        idle(5);
        // Write and read bursts
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        idle(5);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle(5);
        // Write burst with a three-cycle stall starting at burst cycle 2
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        idle(5);
        // Precharge, then a read in idle must raise cmd_err
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        idle(5);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle(2);
        // Reopen, act+wr in active, act during a read burst
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 17'h1ABCD);
        idle(5);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 17'h00001);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 17'h12345);
        idle(5);
        // Reset at burst cycle 2 of a read
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        idle(2);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(0, 99);
            rv = AW'($urandom);
            if (r < 40)      c = 4'b0000;
            else if (r < 88) c = 4'b0001 << $urandom_range(0, 3);
            else             c = 4'($urandom);
            step(($urandom_range(0, 249) == 0), c[0], c[1], c[2], c[3],
                 ($urandom_range(0, 3) == 0), rv);
        end
        idle(1);
        // Let the monitor consume the final entries, bounded
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
